// File: rtl/alphaahb_v5_perf_pkg.sv
// rtl/alphaahb_v5_perf_pkg.sv - shared register map, CTRL layout and event IDs for the perf monitor
package alphaahb_v5_perf_pkg;

  localparam logic [1:0] REG_CNT    = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_SNAP   = 2'd2;
  localparam logic [1:0] REG_GLOBAL = 2'd3;

  localparam int CTRL_EN_BIT     = 8;
  localparam int CTRL_IRQ_EN_BIT = 9;
  localparam int CTRL_OVF_BIT    = 10;

  localparam int GBL_FREEZE_BIT = 0;
  localparam int GBL_CLEAR_BIT  = 1;
  localparam int GBL_SNAP_BIT   = 2;

  localparam int EVT_RETIRE = 0;
  localparam int EVT_CYCLE  = 1;
  localparam int EVT_STALL  = 2;
  localparam int EVT_IMISS  = 3;
  localparam int EVT_DMISS  = 4;
  localparam int EVT_BRMISP = 5;

  // Readback image of CTRL: ovf lands on bit 10, irq_en 9, en 8, evt_sel in [7:0]
  typedef struct packed {
    logic       ovf;
    logic       irq_en;
    logic       en;
    logic [7:0] evt_sel;
  } ctrl_t;

endpackage

// File: rtl/alphaahb_v5_perf_counter.sv
// rtl/alphaahb_v5_perf_counter.sv - one event counter slice with ovf flag and optional shadow (PERF_SNAPSHOT_EN)
module alphaahb_v5_perf_counter
  import alphaahb_v5_perf_pkg::*;
#(
  parameter int CNT_W     = 64,
  parameter int NUM_EVT   = 16,
  parameter int EVT_SEL_W = $clog2(NUM_EVT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_EVT-1:0]   evt,
  input  logic                 freeze,
  input  logic                 clear,
  input  logic                 snap,
  input  logic                 cnt_we,
  input  logic                 ctrl_we,
  input  logic [CNT_W-1:0]     cnt_wdata,
  input  logic [EVT_SEL_W-1:0] sel_wdata,
  input  logic                 en_wdata,
  input  logic                 irq_en_wdata,
  input  logic                 ovf_w1c,
  output logic [CNT_W-1:0]     cnt_q,
  output logic [CNT_W-1:0]     snap_q,
  output ctrl_t                ctrl_q,
  output logic                 irq_req
);

  logic [EVT_SEL_W-1:0] evt_sel;
  logic                 en;
  logic                 irq_en;
  logic                 ovf;
  logic                 hit;
  logic                 wrap;

  // A wrap only counts when the increment actually lands (not overridden by clear or load)
  assign hit  = en & ~freeze & evt[evt_sel];
  assign wrap = hit & (&cnt_q) & ~clear & ~cnt_we;

  // Counter value: clear beats a software load, which beats an event increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (clear)  cnt_q <= '0;
    else if (cnt_we) cnt_q <= cnt_wdata;
    else if (hit)    cnt_q <= cnt_q + 1'b1;
  end

  // Sticky overflow: a new wrap wins over a simultaneous W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ovf <= 1'b0;
    else if (clear)              ovf <= 1'b0;
    else if (wrap)               ovf <= 1'b1;
    else if (ctrl_we && ovf_w1c) ovf <= 1'b0;
  end

  // Configuration fields, untouched by clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_sel <= '0;
      en      <= 1'b0;
      irq_en  <= 1'b0;
    end else if (ctrl_we) begin
      evt_sel <= sel_wdata;
      en      <= en_wdata;
      irq_en  <= irq_en_wdata;
    end
  end

`ifdef PERF_SNAPSHOT_EN
  // Shadow captures the pre-edge value, so snapshot+clear keeps the pre-clear count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    snap_q <= '0;
    else if (snap) snap_q <= cnt_q;
  end
`else
  logic unused_snap;
  assign unused_snap = snap;
  assign snap_q      = '0;
`endif

  assign ctrl_q.ovf     = ovf;
  assign ctrl_q.irq_en  = irq_en;
  assign ctrl_q.en      = en;
  assign ctrl_q.evt_sel = 8'(evt_sel);
  assign irq_req        = ovf & irq_en;

endmodule

// File: rtl/alphaahb_v5_perf_monitor.sv
// rtl/alphaahb_v5_perf_monitor.sv - multi-core PMU top: decode, GLOBAL reg, readback, irq (PERF_SNAPSHOT_EN)
module alphaahb_v5_perf_monitor
  import alphaahb_v5_perf_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NUM_CNT   = 8,
  parameter int CNT_W     = 64,
  parameter int NUM_EVT   = 16,
  parameter int EVT_SEL_W = $clog2(NUM_EVT),
  parameter int A_W       = $clog2(NUM_CORES) + $clog2(NUM_CNT) + 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CORES*NUM_EVT-1:0]       evt_i,
  input  logic                               cfg_we,
  input  logic                               cfg_re,
  input  logic [A_W-1:0]                     cfg_addr,
  input  logic [63:0]                        cfg_wdata,
  output logic [63:0]                        cfg_rdata,
  output logic                               cfg_rvalid,
  output logic [NUM_CORES-1:0]               irq_o,
  output logic [NUM_CORES*NUM_CNT*CNT_W-1:0] perf_counters
);

  localparam int CORE_W = $clog2(NUM_CORES);
  localparam int CIDX_W = $clog2(NUM_CNT);
  localparam int NSLICE = NUM_CORES * NUM_CNT;

  logic [CORE_W-1:0] core_idx;
  logic [CIDX_W-1:0] cnt_idx;
  logic [1:0]        reg_sel;
  logic              in_range;
  logic              global_we;
  logic              clear_p;
  logic              snap_p;
  logic              freeze;
  int                rd_idx;
  logic [63:0]       rd_word;
  logic [NUM_CORES-1:0] irq_d;

  logic [CNT_W-1:0]  cnt_arr  [NSLICE];
  logic [CNT_W-1:0]  snap_arr [NSLICE];
  ctrl_t             ctrl_arr [NSLICE];
  logic [NSLICE-1:0] irq_vec;

  assign core_idx = cfg_addr[A_W-1 -: CORE_W];
  assign cnt_idx  = cfg_addr[2 +: CIDX_W];
  assign reg_sel  = cfg_addr[1:0];
  assign in_range = ({1'b0, core_idx} < (CORE_W+1)'(NUM_CORES)) &&
                    ({1'b0, cnt_idx}  < (CIDX_W+1)'(NUM_CNT));
  assign rd_idx   = int'(core_idx) * NUM_CNT + int'(cnt_idx);

  assign global_we = cfg_we & in_range & (reg_sel == REG_GLOBAL);
  assign clear_p   = global_we & cfg_wdata[GBL_CLEAR_BIT];
  assign snap_p    = global_we & cfg_wdata[GBL_SNAP_BIT];

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
      localparam int IDX = c * NUM_CNT + k;
      logic hit_idx;
      assign hit_idx = cfg_we & in_range & (core_idx == CORE_W'(c)) & (cnt_idx == CIDX_W'(k));

      alphaahb_v5_perf_counter #(
        .CNT_W     (CNT_W),
        .NUM_EVT   (NUM_EVT),
        .EVT_SEL_W (EVT_SEL_W)
      ) u_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .evt          (evt_i[c*NUM_EVT +: NUM_EVT]),
        .freeze       (freeze),
        .clear        (clear_p),
        .snap         (snap_p),
        .cnt_we       (hit_idx & (reg_sel == REG_CNT)),
        .ctrl_we      (hit_idx & (reg_sel == REG_CTRL)),
        .cnt_wdata    (cfg_wdata[CNT_W-1:0]),
        .sel_wdata    (cfg_wdata[EVT_SEL_W-1:0]),
        .en_wdata     (cfg_wdata[CTRL_EN_BIT]),
        .irq_en_wdata (cfg_wdata[CTRL_IRQ_EN_BIT]),
        .ovf_w1c      (cfg_wdata[CTRL_OVF_BIT]),
        .cnt_q        (cnt_arr[IDX]),
        .snap_q       (snap_arr[IDX]),
        .ctrl_q       (ctrl_arr[IDX]),
        .irq_req      (irq_vec[IDX])
      );

      assign perf_counters[IDX*CNT_W +: CNT_W] = cnt_arr[IDX];
    end
    assign irq_d[c] = |irq_vec[c*NUM_CNT +: NUM_CNT];
  end

  // Readback mux over pre-edge state; out-of-range indices read as zero
  always_comb begin
    rd_word = '0;
    if (in_range) begin
      if (reg_sel == REG_GLOBAL) begin
        rd_word = 64'(freeze);
      end else begin
        for (int i = 0; i < NSLICE; i++) begin
          if (i == rd_idx) begin
            case (reg_sel)
              REG_CNT:  rd_word = 64'(cnt_arr[i]);
              REG_CTRL: rd_word = 64'(ctrl_arr[i]);
              REG_SNAP: rd_word = 64'(snap_arr[i]);
              default:  rd_word = '0;
            endcase
          end
        end
      end
    end
  end

  // Freeze flag, one-cycle read response and registered per-core interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freeze     <= 1'b0;
      cfg_rdata  <= '0;
      cfg_rvalid <= 1'b0;
      irq_o      <= '0;
    end else begin
      if (global_we) freeze <= cfg_wdata[GBL_FREEZE_BIT];
      cfg_rvalid <= cfg_re;
      cfg_rdata  <= cfg_re ? rd_word : 64'd0;
      irq_o      <= irq_d;
    end
  end

endmodule

// File: tb/tb_alphaahb_v5_perf_monitor.sv
// tb/tb_alphaahb_v5_perf_monitor.sv - self-checking bench for alphaahb_v5_perf_monitor with reference model
module tb_alphaahb_v5_perf_monitor;

  localparam int NC = 4;
  localparam int NK = 8;
  localparam int CW = 8;
  localparam int NE = 16;
  localparam int AW = 7;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NC*NE-1:0]     evt_i;
  logic                 cfg_we, cfg_re;
  logic [AW-1:0]        cfg_addr;
  logic [63:0]          cfg_wdata;
  logic [63:0]          cfg_rdata;
  logic                 cfg_rvalid;
  logic [NC-1:0]        irq_o;
  logic [NC*NK*CW-1:0]  perf_counters;

  alphaahb_v5_perf_monitor #(
    .NUM_CORES (NC), .NUM_CNT (NK), .CNT_W (CW), .NUM_EVT (NE)
  ) dut (
    .clk (clk), .rst_n (rst_n), .evt_i (evt_i), .cfg_we (cfg_we), .cfg_re (cfg_re),
    .cfg_addr (cfg_addr), .cfg_wdata (cfg_wdata), .cfg_rdata (cfg_rdata),
    .cfg_rvalid (cfg_rvalid), .irq_o (irq_o), .perf_counters (perf_counters)
  );

  always #5 clk = ~clk;

  // Reference model, counts kept as plain integers modulo 2**CW
  int          m_cnt  [NC][NK];
  int          m_snap [NC][NK];
  int          m_sel  [NC][NK];
  bit          m_en   [NC][NK];
  bit          m_ie   [NC][NK];
  bit          m_ovf  [NC][NK];
  bit          m_frz;
  bit [NC-1:0] m_irq;
  logic [63:0] m_rdata;
  bit          m_rvalid;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void model_reset();
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < NK; k++) begin
        m_cnt[c][k] = 0; m_snap[c][k] = 0; m_sel[c][k] = 0;
        m_en[c][k] = 0; m_ie[c][k] = 0; m_ovf[c][k] = 0;
      end
    m_frz = 0; m_irq = '0; m_rdata = '0; m_rvalid = 0;
  endfunction

  function automatic logic [63:0] model_read(logic [AW-1:0] a);
    int c = int'(a[6:5]);
    int k = int'(a[4:2]);
    logic [63:0] v = '0;
    case (a[1:0])
      2'd0: v = 64'(m_cnt[c][k]);
      2'd1: v = 64'(m_sel[c][k]) | (64'(m_en[c][k]) << 8) | (64'(m_ie[c][k]) << 9) | (64'(m_ovf[c][k]) << 10);
`ifdef PERF_SNAPSHOT_EN
      2'd2: v = 64'(m_snap[c][k]);
`else
      2'd2: v = '0;
`endif
      default: v = 64'(m_frz);
    endcase
    return v;
  endfunction

  // Advance the model by one clock edge from the inputs currently driven
  function automatic void model_edge();
    bit [NC-1:0] nirq = '0;
    int wc = int'(cfg_addr[6:5]);
    int wk = int'(cfg_addr[4:2]);
    int r  = int'(cfg_addr[1:0]);
    bit g, clr, snp;
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < NK; k++)
        if (m_ovf[c][k] && m_ie[c][k]) nirq[c] = 1;
    m_rvalid = cfg_re;
    m_rdata  = cfg_re ? model_read(cfg_addr) : 64'd0;
    g   = cfg_we && r == 3;
    clr = g && cfg_wdata[1];
    snp = g && cfg_wdata[2];
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < NK; k++) begin
        bit me = cfg_we && c == wc && k == wk;
        bit wrapped = 0;
        bit hit = m_en[c][k] && !m_frz && evt_i[c*NE + m_sel[c][k]];
        if (snp) m_snap[c][k] = m_cnt[c][k];
        if (clr) begin
          m_cnt[c][k] = 0; m_ovf[c][k] = 0;
        end else if (me && r == 0) begin
          m_cnt[c][k] = int'(cfg_wdata[7:0]);
        end else if (hit) begin
          if (m_cnt[c][k] == 255) begin
            m_cnt[c][k] = 0; m_ovf[c][k] = 1; wrapped = 1;
          end else m_cnt[c][k] = m_cnt[c][k] + 1;
        end
        if (me && r == 1) begin
          m_sel[c][k] = int'(cfg_wdata[3:0]);
          m_en[c][k]  = cfg_wdata[8];
          m_ie[c][k]  = cfg_wdata[9];
          if (cfg_wdata[10] && !wrapped) m_ovf[c][k] = 0;
        end
      end
    if (g) m_frz = cfg_wdata[0];
    m_irq = nirq;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [63:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [63:0] d, output logic v);
    cfg_addr = a; cfg_re = 1'b1;
    tick();
    cfg_re = 1'b0;
    d = cfg_rdata; v = cfg_rvalid;
  endtask

  task automatic test_reset();
    wr(7'd1, 64'h100);
    evt_i = 64'd1;
    repeat (5) tick();
    evt_i = '0;
    n_cmp++;
    if (perf_counters[7:0] !== 8'd5) begin
      n_bad++; $display("FAIL reset_precount: got %0d want 5", perf_counters[7:0]);
    end
    cfg_addr = 7'd0; cfg_re = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    cfg_re = 1'b0;
    model_reset();
    n_cmp++;
    if (cfg_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", cfg_rvalid); end
    n_cmp++;
    if (cfg_rdata !== 64'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", cfg_rdata); end
    n_cmp++;
    if (irq_o !== '0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq_o); end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (perf_counters !== '0) begin n_bad++; $display("FAIL reset_counters: got %h want 0", perf_counters); end
    n_cmp++;
    if (cfg_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid_after: got %b want 0", cfg_rvalid); end
  endtask

  task automatic test_count();
    logic [63:0] d; logic v;
    wr(7'd41, 64'h101);
    evt_i = '0; evt_i[1*NE+1] = 1'b1;
    repeat (100) tick();
    evt_i = '0;
    cfg_addr = 7'd40; cfg_re = 1'b1; #1;
    n_cmp++;
    if (cfg_rvalid !== 1'b0) begin n_bad++; $display("FAIL count_rvalid_early: got %b want 0", cfg_rvalid); end
    tick();
    cfg_re = 1'b0; d = cfg_rdata; v = cfg_rvalid;
    n_cmp++;
    if (v !== 1'b1) begin n_bad++; $display("FAIL count_rvalid: got %b want 1", v); end
    n_cmp++;
    if (d !== 64'd100) begin n_bad++; $display("FAIL count_value: got %0d want 100", d); end
    tick();
    n_cmp++;
    if (cfg_rvalid !== 1'b0) begin n_bad++; $display("FAIL count_rvalid_one_cycle: got %b want 0", cfg_rvalid); end
  endtask

  task automatic test_overflow();
    logic [63:0] d; logic v;
    wr(7'd40, 64'hFE);
    wr(7'd41, 64'h301);
    evt_i = '0; evt_i[1*NE+1] = 1'b1;
    tick(); tick();
    evt_i = '0;
    n_cmp++;
    if (perf_counters[10*CW +: CW] !== 8'h00) begin
      n_bad++; $display("FAIL ovf_wrap_value: got %h want 00", perf_counters[10*CW +: CW]);
    end
    n_cmp++;
    if (irq_o[1] !== 1'b0) begin n_bad++; $display("FAIL ovf_irq_latency: got %b want 0", irq_o[1]); end
    rd(7'd41, d, v);
    n_cmp++;
    if (v !== 1'b1 || d !== 64'h701) begin n_bad++; $display("FAIL ovf_ctrl: got %h/%b want 701/1", d, v); end
    n_cmp++;
    if (irq_o[1] !== 1'b1) begin n_bad++; $display("FAIL ovf_irq_set: got %b want 1", irq_o[1]); end
    wr(7'd41, 64'h701);
    tick();
    n_cmp++;
    if (irq_o[1] !== 1'b0) begin n_bad++; $display("FAIL ovf_irq_w1c: got %b want 0", irq_o[1]); end
  endtask

  task automatic test_freeze();
    int s0, s1;
    wr(7'd1, 64'h100);
    wr(7'd85, 64'h103);
    evt_i = '1;
    repeat (3) tick();
    wr(7'd3, 64'h1);
    s0 = m_cnt[0][0]; s1 = m_cnt[2][5];
    repeat (50) tick();
    n_cmp++;
    if (perf_counters[0 +: CW] !== 8'(s0)) begin
      n_bad++; $display("FAIL freeze_hold0: got %0d want %0d", perf_counters[0 +: CW], s0);
    end
    n_cmp++;
    if (perf_counters[21*CW +: CW] !== 8'(s1)) begin
      n_bad++; $display("FAIL freeze_hold1: got %0d want %0d", perf_counters[21*CW +: CW], s1);
    end
    wr(7'd3, 64'h0);
    repeat (5) tick();
    evt_i = '0;
    n_cmp++;
    if (perf_counters[21*CW +: CW] !== 8'(s1 + 5)) begin
      n_bad++; $display("FAIL freeze_resume: got %0d want %0d", perf_counters[21*CW +: CW], s1 + 5);
    end
  endtask

  task automatic test_clear();
    logic [63:0] d; logic v;
    wr(7'd40, 64'hFF);
    evt_i = '0; evt_i[1*NE+1] = 1'b1;
    tick();
    wr(7'd3, 64'h2);
    evt_i = '0;
    n_cmp++;
    if (perf_counters !== '0) begin n_bad++; $display("FAIL clear_counters: got %h want 0", perf_counters); end
    rd(7'd41, d, v);
    n_cmp++;
    if (d !== 64'h301) begin n_bad++; $display("FAIL clear_ctrl_kept: got %h want 301", d); end
    evt_i[1*NE+1] = 1'b1;
    wr(7'd40, 64'h55);
    evt_i = '0;
    rd(7'd40, d, v);
    n_cmp++;
    if (d !== 64'h55) begin n_bad++; $display("FAIL load_over_inc: got %h want 55", d); end
  endtask

  task automatic test_back_to_back();
    cfg_addr = 7'd40; cfg_wdata = 64'h11; cfg_we = 1'b1; cfg_re = 1'b1;
    tick();
    cfg_we = 1'b0;
    n_cmp++;
    if (cfg_rdata !== 64'h55) begin n_bad++; $display("FAIL rw_old_value: got %h want 55", cfg_rdata); end
    tick();
    cfg_re = 1'b0;
    n_cmp++;
    if (cfg_rvalid !== 1'b1 || cfg_rdata !== 64'h11) begin
      n_bad++; $display("FAIL rw_new_value: got %h/%b want 11/1", cfg_rdata, cfg_rvalid);
    end
  endtask

  task automatic test_snapshot();
    logic [63:0] d; logic v;
    logic [63:0] want;
    wr(7'd3, 64'h2);
    wr(7'd125, 64'h102);
    evt_i = '0; evt_i[3*NE+2] = 1'b1;
    repeat (40) tick();
    evt_i = '0;
    wr(7'd3, 64'h4);
    evt_i[3*NE+2] = 1'b1;
    repeat (10) tick();
    evt_i = '0;
`ifdef PERF_SNAPSHOT_EN
    want = 64'd40;
`else
    want = 64'd0;
`endif
    rd(7'd126, d, v);
    n_cmp++;
    if (d !== want) begin n_bad++; $display("FAIL snap_value: got %0d want %0d", d, want); end
    rd(7'd124, d, v);
    n_cmp++;
    if (d !== 64'd50) begin n_bad++; $display("FAIL snap_live_cnt: got %0d want 50", d); end
    wr(7'd3, 64'h6);
`ifdef PERF_SNAPSHOT_EN
    want = 64'd50;
`else
    want = 64'd0;
`endif
    rd(7'd126, d, v);
    n_cmp++;
    if (d !== want) begin n_bad++; $display("FAIL snap_with_clear: got %0d want %0d", d, want); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int op = $urandom_range(0, 9);
      evt_i = {$urandom(), $urandom()};
      cfg_addr = AW'($urandom());
      cfg_we = (op < 3);
      cfg_re = (op >= 2 && op < 6);
      if (cfg_addr[1:0] == 2'd3) begin
        cfg_wdata = 64'($urandom_range(0, 7));
        if ($urandom_range(0, 3) != 0) cfg_wdata[1] = 1'b0;
      end else cfg_wdata = {$urandom(), $urandom()};
      tick();
      cfg_we = 1'b0; cfg_re = 1'b0;
      for (int c = 0; c < NC; c++)
        for (int k = 0; k < NK; k++) begin
          n_cmp++;
          if (perf_counters[(c*NK+k)*CW +: CW] !== 8'(m_cnt[c][k])) begin
            n_bad++;
            $display("FAIL rand_cnt c%0d k%0d cyc%0d: got %0d want %0d", c, k, n,
                     perf_counters[(c*NK+k)*CW +: CW], m_cnt[c][k]);
          end
        end
      n_cmp++;
      if (irq_o !== m_irq) begin n_bad++; $display("FAIL rand_irq cyc%0d: got %b want %b", n, irq_o, m_irq); end
      n_cmp++;
      if (cfg_rvalid !== m_rvalid) begin
        n_bad++; $display("FAIL rand_rvalid cyc%0d: got %b want %b", n, cfg_rvalid, m_rvalid);
      end
      if (m_rvalid) begin
        n_cmp++;
        if (cfg_rdata !== m_rdata) begin
          n_bad++; $display("FAIL rand_rdata cyc%0d: got %h want %h", n, cfg_rdata, m_rdata);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; evt_i = '0; cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_count();
    test_overflow();
    test_freeze();
    test_clear();
    test_back_to_back();
    test_snapshot();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
